// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CNT performance counters of CNT_W bits each.
// Counter 0 counts cycles and is frozen by halt. Counters 1.. count pulses on ev[i].
// Each counter has a per-counter inhibit bit and a sticky overflow flag.
// Counters are read and written as 32-bit halves selected by index plus a half-select bit.
//
// Read protocol: rd_en is a single-cycle request with no back-pressure.
//   The request is sampled on a clock edge.
//   rd_data then shows the pre-edge counter value from that edge onward.
//   rd_data holds that value until the next rd_en.
//
// Coherent 64-bit reads (SNAPSHOT=1):
//   A low-half read also captures the counter's high half in a shadow register.
//   A later high-half read of the same index returns the shadow, not the live value.
//   A write to the shadowed counter invalidates the shadow.
module perf_counter_bank #(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 64,
  parameter int SNAPSHOT = 1,
  parameter int IDX_W    = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               halt,
  input  logic [NUM_CNT-1:0] ev,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_hi,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_hi,
  input  logic [31:0]        wr_data,
  input  logic               inh_wr,
  input  logic [NUM_CNT-1:0] inh_data,
  output logic [NUM_CNT-1:0] inh_q,
  output logic [NUM_CNT-1:0] ovf
);

  // The high half of a counter only exists when the counter is wider than 32 bits.
  localparam bit HI_WRITABLE = (CNT_W > 32);

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [IDX_W-1:0]   shadow_idx_q, shadow_idx_d;
  logic               shadow_vld_q, shadow_vld_d;
  logic               wr_ok;
  logic [63:0]        rd_full;
  logic               snap_hit;

  // Zero-extend a counter value to the 64-bit architectural view.
  function automatic logic [63:0] widen(input logic [CNT_W-1:0] v);
    logic [63:0] w;
    w = '0;
    w[CNT_W-1:0] = v;
    return w;
  endfunction

  // Compute the next value and overflow flag of each counter.
  // A write takes priority over that cycle's increment.
  always_comb begin
    logic [63:0] full;
    logic        inc;
    logic        wr_hit;
    wr_ok = wr_en && (!wr_hi || HI_WRITABLE);
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      full     = widen(cnt_q[i]);
      inc      = (i == 0) ? (!halt && !inh_q[0]) : (ev[i] && !inh_q[i]);
      wr_hit   = wr_ok && (wr_idx == IDX_W'(i));
      cnt_d[i] = cnt_q[i];
      if (wr_hit) begin
        if (wr_hi) full[63:32] = wr_data;
        else       full[31:0]  = wr_data;
        cnt_d[i] = full[CNT_W-1:0];
        ovf_d[i] = 1'b0;
      end else if (inc) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (&cnt_q[i]) ovf_d[i] = 1'b1;
      end
    end
  end

  // Select the read word from the pre-update counters and the snapshot shadow.
  // A new low-half read refreshes the shadow.
  always_comb begin
    rd_full = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) rd_full = widen(cnt_q[i]);
    end
    snap_hit     = (SNAPSHOT != 0) && shadow_vld_q && (shadow_idx_q == rd_idx);
    rd_data_d    = rd_hi ? (snap_hit ? shadow_q : rd_full[63:32]) : rd_full[31:0];
    shadow_d     = shadow_q;
    shadow_idx_d = shadow_idx_q;
    shadow_vld_d = shadow_vld_q && !(wr_ok && (wr_idx == shadow_idx_q));
    if (rd_en && !rd_hi) begin
      shadow_d     = rd_full[63:32];
      shadow_idx_d = rd_idx;
      shadow_vld_d = !(wr_ok && (wr_idx == rd_idx));
    end
  end

  // Counter and overflow state; reset overrides writes and events.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '{default: '0};
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Inhibit mask; the cycle in which inh_wr is asserted still uses the old mask.
  always_ff @(posedge clk) begin
    if (!resetn)     inh_q <= '0;
    else if (inh_wr) inh_q <= inh_data;
  end

  // Registered read data and snapshot shadow, both updated only on a read request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q    <= '0;
      shadow_q     <= '0;
      shadow_idx_q <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      if (rd_en) rd_data_q <= rd_data_d;
      if (rd_en && !rd_hi) begin
        shadow_q     <= shadow_d;
        shadow_idx_q <= shadow_idx_d;
      end
      shadow_vld_q <= shadow_vld_d;
    end
  end

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank.
// Two instances share the same stimulus:
//   u_dut   - default 64-bit counters with snapshot enabled
//   u_dut40 - 40-bit counters
// Outputs are sampled 1 time unit after each rising edge.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic        halt;
  logic [3:0]  ev;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic        rd_hi;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        wr_hi;
  logic [31:0] wr_data;
  logic        inh_wr;
  logic [3:0]  inh_data;
  logic [31:0] rd_data, rd_data40;
  logic [3:0]  inh_q, inh_q40, ovf, ovf40;

  int n_assert = 0;
  int n_fail   = 0;

  // Clock
  always #5 clk = ~clk;

  perf_counter_bank u_dut (
    .clk(clk), .resetn(resetn), .halt(halt), .ev(ev),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data),
    .inh_wr(inh_wr), .inh_data(inh_data), .inh_q(inh_q), .ovf(ovf)
  );

  perf_counter_bank #(.CNT_W(40)) u_dut40 (
    .clk(clk), .resetn(resetn), .halt(halt), .ev(ev),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data40),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data),
    .inh_wr(inh_wr), .inh_data(inh_data), .inh_q(inh_q40), .ovf(ovf40)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic hi, input logic [31:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_hi = hi; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic hi);
    rd_en = 1'b1; rd_idx = idx; rd_hi = hi;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; halt = 1'b0; ev = '0;
    rd_en = 1'b0; rd_idx = '0; rd_hi = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_hi = 1'b0; wr_data = '0;
    inh_wr = 1'b0; inh_data = '0;

    // Reset state
    tick(); tick();
    check("reset_rd_data",   rd_data,   0);
    check("reset_ovf",       ovf,       0);
    check("reset_inh",       inh_q,     0);
    check("reset_rd_data40", rd_data40, 0);
    check("reset_ovf40",     ovf40,     0);

    // Ten free-running cycles, then read cycle counter in cycle 11
    resetn = 1'b1;
    repeat (10) tick();
    rd(4'd0, 1'b0);
    check("cycle_after_10", rd_data, 32'd10);
    halt = 1'b1;
    rd(4'd1, 1'b0);
    check("instret_zero", rd_data, 0);
    check("ovf_clear_t1", ovf, 0);

    // Counter 1 wrap sets ovf, write clears it
    wr(4'd1, 1'b0, 32'hFFFF_FFFF);
    wr(4'd1, 1'b1, 32'hFFFF_FFFF);
    ev = 4'b0010; tick(); ev = '0;
    rd(4'd1, 1'b0);
    check("wrap_lo", rd_data, 0);
    check("wrap_ovf1", ovf[1], 1);
    rd(4'd1, 1'b1);
    check("wrap_hi", rd_data, 0);
    wr(4'd1, 1'b0, 32'd5);
    check("write_clears_ovf1", ovf[1], 0);
    rd(4'd1, 1'b0);
    check("write_lo_5", rd_data, 32'd5);

    // Write beats same-cycle increment; read returns pre-update value
    wr_en = 1'b1; wr_idx = 4'd2; wr_hi = 1'b0; wr_data = 32'd7; ev = 4'b0100;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_idx = 4'd2; rd_hi = 1'b0;
    tick();
    check("write_wins_7", rd_data, 32'd7);
    ev = '0;
    tick();
    rd_en = 1'b0;
    check("next_inc_8", rd_data, 32'd8);

    // Snapshot of cycle counter across a carry into the high half
    wr(4'd1, 1'b1, 32'h0000_ABCD);
    wr(4'd0, 1'b1, 32'h0);
    wr(4'd0, 1'b0, 32'hFFFF_FFFE);
    halt = 1'b0;
    rd(4'd0, 1'b0);
    check("snap_lo", rd_data, 32'hFFFF_FFFE);
    repeat (3) tick();
    halt = 1'b1;
    rd(4'd0, 1'b1);
    check("snap_hi_shadow", rd_data, 0);
    rd(4'd1, 1'b1);
    check("other_idx_live_hi", rd_data, 32'h0000_ABCD);
    rd(4'd1, 1'b0);
    check("cnt1_lo", rd_data, 32'd5);
    rd(4'd0, 1'b1);
    check("cnt0_live_hi", rd_data, 32'd1);

    // Inhibit: inh_wr cycle still counts, then counter 0 freezes
    wr(4'd0, 1'b1, 32'h0);
    wr(4'd0, 1'b0, 32'h0);
    halt = 1'b0; inh_wr = 1'b1; inh_data = 4'b0001;
    tick();
    inh_wr = 1'b0;
    repeat (4) tick();
    check("inh_mask", inh_q, 4'b0001);
    rd(4'd0, 1'b0);
    check("inh_freeze", rd_data, 32'd1);
    halt = 1'b1; inh_wr = 1'b1; inh_data = 4'b0000;
    tick();
    inh_wr = 1'b0;
    repeat (3) tick();
    check("inh_cleared", inh_q, 0);
    rd(4'd0, 1'b0);
    check("halt_freeze", rd_data, 32'd1);

    // Wrap of an all-ones counter in both widths
    wr(4'd3, 1'b1, 32'hFFFF_FFFF);
    wr(4'd3, 1'b0, 32'hFFFF_FFFF);
    ev = 4'b1000; tick(); ev = '0;
    check("wrap_ovf3",   ovf[3],   1);
    check("wrap_ovf3_40", ovf40[3], 1);
    rd(4'd3, 1'b0);
    check("wrap3_lo",   rd_data,   0);
    check("wrap3_lo40", rd_data40, 0);
    rd(4'd3, 1'b1);
    check("wrap3_hi",   rd_data,   0);
    check("wrap3_hi40", rd_data40, 0);

    // High-half write truncation; the write invalidates the shadow
    wr(4'd3, 1'b1, 32'h0001_2345);
    check("hi_write_clears_ovf3",   ovf[3],   0);
    check("hi_write_clears_ovf3_40", ovf40[3], 0);
    rd(4'd3, 1'b1);
    check("hi_write_64", rd_data,   32'h0001_2345);
    check("hi_write_40", rd_data40, 32'h45);
    rd(4'd4, 1'b0);
    check("oob_idx",   rd_data,   0);
    check("oob_idx40", rd_data40, 0);

    // Reset mid-count overrides write, inhibit load and events
    halt = 1'b0; ev = 4'b1111;
    rd(4'd0, 1'b0);
    check("pre_reset_cnt0",   rd_data,   32'd1);
    check("pre_reset_cnt0_40", rd_data40, 32'd1);
    tick();
    resetn = 1'b0;
    wr_en = 1'b1; wr_idx = 4'd2; wr_data = 32'h99; wr_hi = 1'b0;
    inh_wr = 1'b1; inh_data = 4'b1111;
    rd_en = 1'b1; rd_idx = 4'd0; rd_hi = 1'b0;
    tick();
    check("mid_reset_rd_data",   rd_data,   0);
    check("mid_reset_rd_data40", rd_data40, 0);
    check("mid_reset_ovf",       ovf,       0);
    check("mid_reset_inh",       inh_q,     0);
    check("mid_reset_inh40",     inh_q40,   0);
    resetn = 1'b1; halt = 1'b1; ev = '0;
    wr_en = 1'b0; inh_wr = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(4'(i), 1'b0);
      check($sformatf("post_reset_cnt%0d", i), rd_data, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
